// File: rtl/xl_tick_gen.sv
// -----------------------------------------------------------------------------
// xl_tick_gen
//
// Programmable periodic / one-shot tick generator. The static `period` and
// `oneshot` settings are turned into a registered single-cycle `tick` stream.
//
// A down-counter is loaded with period-1 when a run starts and reloaded at
// every terminal count. `tick` is high for the cycle that follows a terminal
// count. `period` and `oneshot` are sampled only at load and reload, so a
// change in the middle of a period takes effect at the next reload.
//
// Optional feature (macro XL_TICK_GEN_COUNT_EN):
//   defined   : tick_count counts emitted ticks and wraps modulo 2^COUNT_WIDTH.
//               Only rst clears it; disable and re-arm leave it unchanged.
//   undefined : no counter is built and tick_count is tied to zero. The port
//               is still present.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, wins over everything
//   enable     in   level-sensitive run request
//   oneshot    in   1 = one tick then stop, 0 = periodic
//   period     in   tick spacing in cycles, 0 = no ticks
//   tick       out  registered one-cycle pulse
//   busy       out  high while the FSM is in RUN
//   tick_count out  running tick count (zero when the counter is not built)
// -----------------------------------------------------------------------------
`default_nettype none

module xl_tick_gen #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    oneshot,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    tick,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  tick_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ZERO = {PERIOD_WIDTH{1'b0}};
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE  = PERIOD_WIDTH'(1'b1);

  state_t                  state_r;
  logic [PERIOD_WIDTH-1:0] cnt_r;
  logic                    oneshot_r;
  logic                    tick_r;
  logic                    busy_r;

  // A terminal count only fires while still enabled, so a disable on the
  // same edge suppresses the tick.
  logic fire_s;
  assign fire_s = (state_r == ST_RUN) && enable && (cnt_r == PERIOD_ZERO);

  // Control FSM: run state, down-counter, latched mode, tick and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= PERIOD_ZERO;
      oneshot_r <= 1'b0;
      tick_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      // A tick is produced only by the terminal-count branch below.
      tick_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable && (period != PERIOD_ZERO)) begin
            state_r   <= ST_RUN;
            cnt_r     <= period - PERIOD_ONE;
            oneshot_r <= oneshot;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= PERIOD_ZERO;
            busy_r  <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state_r <= ST_IDLE;
            cnt_r   <= PERIOD_ZERO;
            busy_r  <= 1'b0;
          end else if (cnt_r != PERIOD_ZERO) begin
            cnt_r <= cnt_r - PERIOD_ONE;
          end else begin
            tick_r <= 1'b1;
            if (oneshot_r) begin
              // busy falls on the same edge that raises the single tick.
              state_r <= ST_DONE;
              cnt_r   <= PERIOD_ZERO;
              busy_r  <= 1'b0;
            end else if (period == PERIOD_ZERO) begin
              // period-1 is never formed for a zero period.
              state_r <= ST_IDLE;
              cnt_r   <= PERIOD_ZERO;
              busy_r  <= 1'b0;
            end else begin
              cnt_r     <= period - PERIOD_ONE;
              oneshot_r <= oneshot;
            end
          end
        end

        ST_DONE: begin
          // Re-arming needs enable low for at least one cycle.
          if (!enable) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
          cnt_r  <= PERIOD_ZERO;
          busy_r <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= PERIOD_ZERO;
          oneshot_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign tick = tick_r;
  assign busy = busy_r;

`ifdef XL_TICK_GEN_COUNT_EN
  logic [COUNT_WIDTH-1:0] tick_count_r;

  // Tick counter: counts on every edge that sets tick and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (fire_s) begin
      tick_count_r <= tick_count_r + COUNT_WIDTH'(1'b1);
    end else begin
      tick_count_r <= tick_count_r;
    end
  end

  assign tick_count = tick_count_r;
`else
  assign tick_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_xl_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_xl_tick_gen
//
// Scoreboard bench for xl_tick_gen. Stimulus pushes the cycle number and the
// tick_count value of every tick it expects into a queue. A monitor pops one
// entry for each tick the DUT raises. cyc is the number of rising edges seen,
// so an edge numbered k is observed while cyc == k. The DUT is built with
// COUNT_WIDTH = 4 so that the wrap case is short. When XL_TICK_GEN_COUNT_EN
// is not defined, every expected count is zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_xl_tick_gen;

`ifdef XL_TICK_GEN_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic        oneshot;
  logic [15:0] period;
  logic        tick;
  logic        busy;
  logic [3:0]  tick_count;

  xl_tick_gen #(.PERIOD_WIDTH(16), .COUNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .oneshot    (oneshot),
    .period     (period),
    .tick       (tick),
    .busy       (busy),
    .tick_count (tick_count)
  );

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_cnt;
  int         checks;
  int         errors;
  int         cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp ticks.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick consumes one scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick at cyc=%0d count=%0d", cyc, tick_count);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || tick_count !== e.cnt) begin
          errors++;
          $display("FAIL tick_match got cyc=%0d count=%0d want cyc=%0d count=%0d",
                   cyc, tick_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic push_tick(input int c);
    exp_t e;
    exp_cnt = exp_cnt + 4'd1;
    e.cyc = c;
    e.cnt = COUNT_ON ? exp_cnt : 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_ticks got=%0d want=0 next_cyc=%0d", name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Call at a falling edge. Returns at the falling edge where cyc == target.
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Two reset cycles followed by release. Ends on a falling edge.
  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; oneshot = 1'b0; period = 16'd0;
    exp_q.delete();
    exp_cnt = 4'd0;
    wait_cyc(cyc + 2);
    rst = 1'b0;
  endtask

  // Starts a run. The next rising edge is T0.
  task automatic arm(input logic [15:0] p, input logic os, output int t0);
    period = p; oneshot = os; enable = 1'b1;
    t0 = cyc + 1;
  endtask

  initial begin
    int t0;
    rst = 1'b1; enable = 1'b0; oneshot = 1'b0; period = 16'd0;
    exp_cnt = 4'd0; checks = 0; errors = 0;
    @(negedge clk);

    // Reset held for 3 cycles with enable=1 and period=4.
    enable = 1'b1; period = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {29'd0, tick, busy, (tick_count != 4'd0)}, 32'd0);
    end
    rst = 1'b0;
    t0 = cyc + 1;
    push_tick(t0 + 4);
    push_tick(t0 + 8);
    wait_cyc(t0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 9);
    enable = 1'b0;
    wait_cyc(t0 + 12);
    check("busy_after_disable", {31'd0, busy}, 32'd0);
    check_empty("reset_phase");

    // Periodic operation with period 5: ticks at T0+5 ... T0+30.
    do_reset();
    arm(16'd5, 1'b0, t0);
    for (int k = 1; k <= 6; k++) push_tick(t0 + 5 * k);
    wait_cyc(t0 + 30);
    enable = 1'b0;
    wait_cyc(t0 + 31);
    check("periodic_count", {28'd0, tick_count}, COUNT_ON ? 32'd6 : 32'd0);
    check("periodic_busy_off", {31'd0, busy}, 32'd0);
    wait_cyc(t0 + 40);
    check_empty("periodic");

    // Period 1 gives a continuous tick. Period 0 then ends the run at the next reload.
    do_reset();
    arm(16'd1, 1'b0, t0);
    for (int k = 1; k <= 11; k++) push_tick(t0 + k);
    wait_cyc(t0 + 10);
    period = 16'd0;
    wait_cyc(t0 + 12);
    check("period0_busy", {31'd0, busy}, 32'd0);
    wait_cyc(t0 + 20);
    check_empty("period1_then_0");
    enable = 1'b0;

    // One-shot with period 3, followed by a re-arm.
    do_reset();
    arm(16'd3, 1'b1, t0);
    push_tick(t0 + 3);
    wait_cyc(t0 + 2);
    check("oneshot_busy_run", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 3);
    check("oneshot_busy_fall", {31'd0, busy}, 32'd0);
    wait_cyc(t0 + 10);
    check_empty("oneshot_first");
    enable = 1'b0;
    wait_cyc(t0 + 11);
    enable = 1'b1;
    push_tick(t0 + 15);
    wait_cyc(t0 + 13);
    check("rearm_busy", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 20);
    check("oneshot_done_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    check_empty("oneshot_rearm");

    // Disable on the terminal-count edge T0+12 suppresses that tick.
    do_reset();
    arm(16'd4, 1'b0, t0);
    push_tick(t0 + 4);
    push_tick(t0 + 8);
    wait_cyc(t0 + 11);
    enable = 1'b0;
    wait_cyc(t0 + 12);
    check("abort_busy", {31'd0, busy}, 32'd0);
    wait_cyc(t0 + 16);
    check_empty("abort");

    // Reset mid-run with period 8 lands on the terminal-count edge T0+16.
    do_reset();
    arm(16'd8, 1'b0, t0);
    push_tick(t0 + 8);
    wait_cyc(t0 + 12);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + 15);
    rst = 1'b1;
    wait_cyc(t0 + 16);
    check("midrst_tick", {31'd0, tick}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_count", {28'd0, tick_count}, 32'd0);
    rst = 1'b0; enable = 1'b0; exp_cnt = 4'd0;
    wait_cyc(t0 + 22);
    check_empty("midrst");

    // Counter wrap with period 1: the 16th tick reads 0 and the 17th reads 1.
    do_reset();
    arm(16'd1, 1'b0, t0);
    for (int k = 1; k <= 17; k++) push_tick(t0 + k);
    wait_cyc(t0 + 17);
    enable = 1'b0;
    wait_cyc(t0 + 18);
    check("wrap_final_count", {28'd0, tick_count}, COUNT_ON ? 32'd1 : 32'd0);
    wait_cyc(t0 + 22);
    check_empty("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
